// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned divider: state encoding,
// default operand width and the matching step-counter width.
package divu_pkg;

  localparam int DIVU_WIDTH = 32;
  localparam int DIVU_CNT_W = $clog2(DIVU_WIDTH) + 1;

  typedef enum logic [1:0] {
    DIVU_IDLE = 2'd0,
    DIVU_RUN  = 2'd1,
    DIVU_DONE = 2'd2
  } divu_state_e;

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH:0]   trial_s;

  // r stays below 2^(step) while shifting, so its top bit is zero here and
  // the extra bit of trial_s only ever carries the borrow.
  assign shifted_s = {r[WIDTH-2:0], q[WIDTH-1]};
  assign trial_s   = {r, q[WIDTH-1]} - {1'b0, d};

  assign r_next = trial_s[WIDTH] ? shifted_s : trial_s[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~trial_s[WIDTH]};

endmodule

// File: rtl/divu_seq.sv
// Sequential 32-cycle unsigned divider (DIVU): quotient to LO, remainder to
// HI. All state advances on the falling clock edge.
module divu_seq
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  divu_state_e      state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] r_next_s;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_r),
    .q      (q_r),
    .d      (d_r),
    .r_next (r_next_s),
    .q_next (q_next_s)
  );

  // Sequencer: accept operands, iterate one quotient bit per edge, publish.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_r   <= DIVU_IDLE;
      cnt_r     <= {CW{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      r_r       <= {WIDTH{1'b0}};
      d_r       <= {WIDTH{1'b0}};
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        DIVU_IDLE, DIVU_DONE: begin
          done <= 1'b0;
          if (start) begin
            q_r     <= dividend;
            d_r     <= divisor;
            r_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= DIVU_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= DIVU_IDLE;
          end
        end
        DIVU_RUN: begin
          q_r   <= q_next_s;
          r_r   <= r_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            quotient  <= q_next_s;
            remainder <= r_next_s;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= DIVU_DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= DIVU_RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= DIVU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq: directed cases from the DIVU behaviour
// plus randomized operands against a plain-arithmetic reference.
module tb_divu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Inputs change on the rising edge; the DUT samples on the falling edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit busy_ok, output bit hold_ok);
    logic [31:0] q0, r0;
    q0 = quotient;
    r0 = remainder;
    cyc = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (quotient !== q0 || remainder !== r0) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(posedge clk);
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h want=0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h want=0", remainder); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit busy_ok, hold_ok;
    issue(32'd100, 32'd7);
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL basic_latency got=%0d want=32", cyc); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL basic_busy got=0 want=1 while running"); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL basic_hold got=changed want=stable while busy"); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient got=%0d want=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder got=%0d want=2", remainder); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b want=0", busy); end
    @(posedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_result_held got=%0d want=14", quotient); end
  endtask

  task automatic test_edges();
    logic [31:0] a_tab [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1234};
    logic [31:0] b_tab [4] = '{32'd1, 32'hFFFF_FFFF, 32'd9, 32'd0};
    logic [31:0] q_tab [4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] r_tab [4] = '{32'd0, 32'd0, 32'd5, 32'd1234};
    int cyc; bit busy_ok, hold_ok;
    for (int i = 0; i < 4; i++) begin
      issue(a_tab[i], b_tab[i]);
      wait_done(cyc, busy_ok, hold_ok);
      checks++; if (cyc !== 32) begin errors++; $display("FAIL edge%0d_latency got=%0d want=32", i, cyc); end
      checks++; if (quotient !== q_tab[i]) begin errors++; $display("FAIL edge%0d_quotient got=%h want=%h", i, quotient, q_tab[i]); end
      checks++; if (remainder !== r_tab[i]) begin errors++; $display("FAIL edge%0d_remainder got=%h want=%h", i, remainder, r_tab[i]); end
    end
  endtask

  task automatic test_ignore_busy();
    int cyc; bit busy_ok, hold_ok;
    issue(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    start    = 1'b0;
    dividend = 32'd1;
    divisor  = 32'd1;
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc + 11 !== 32) begin errors++; $display("FAIL ignore_latency got=%0d want=32", cyc + 11); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL ignore_quotient got=%0d want=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL ignore_remainder got=%0d want=2", remainder); end
    @(posedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got=%b want=0", busy); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit busy_ok, hold_ok;
    issue(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", done); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL abort_quotient got=%h want=0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL abort_remainder got=%h want=0", remainder); end
    start = 1'b1;
    @(posedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_over_start got=%b want=0", busy); end
    start = 1'b0;
    reset = 1'b0;
    issue(32'd81, 32'd9);
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL abort_latency got=%0d want=32", cyc); end
    checks++; if (quotient !== 32'd9) begin errors++; $display("FAIL abort_quotient2 got=%0d want=9", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL abort_remainder2 got=%0d want=0", remainder); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit busy_ok, hold_ok;
    @(posedge clk);
    dividend = 32'd1000;
    divisor  = 32'd33;
    start    = 1'b1;
    @(posedge clk);
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL b2b_latency1 got=%0d want=32", cyc); end
    checks++; if (quotient !== 32'd30) begin errors++; $display("FAIL b2b_quotient1 got=%0d want=30", quotient); end
    checks++; if (remainder !== 32'd10) begin errors++; $display("FAIL b2b_remainder1 got=%0d want=10", remainder); end
    @(posedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got=%b want=1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b want=0", done); end
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL b2b_latency2 got=%0d want=32", cyc); end
    checks++; if (quotient !== 32'd30) begin errors++; $display("FAIL b2b_quotient2 got=%0d want=30", quotient); end
    checks++; if (remainder !== 32'd10) begin errors++; $display("FAIL b2b_remainder2 got=%0d want=10", remainder); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er;
    int cyc; bit busy_ok, hold_ok;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'($urandom_range(1, 65535));
        default: b = $urandom | 32'h8000_0000;
      endcase
      ref_div(a, b, eq, er);
      issue(a, b);
      wait_done(cyc, busy_ok, hold_ok);
      checks++; if (cyc !== 32) begin errors++; $display("FAIL rand%0d_latency got=%0d want=32", i, cyc); end
      checks++; if (quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL rand%0d_result %h/%h got q=%h r=%h want q=%h r=%h", i, a, b, quotient, remainder, eq, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
